bitstream_reader: RTL and testbench
===================================

Name: bitstream_reader

Overview:
- Read-side engine for the 32-bit-wide dual-port bitstream buffer (512 words). The Ethernet side writes the buffer through port A; this block drives port B.
- Fetches words in order and exposes a left-justified 32-bit bit window to the MPEG bitstream parser.
- The parser consumes 0..32 bits per cycle.
- Exports its word read pointer so the writer can compute free space.

Parameters:
- ADDR_WIDTH, 9, buffer word-address width; equals `BITSTR_BUFFER_ADDR_WIDTH.

Ports:
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Write_Ptr_I  input  ADDR_WIDTH+1  writer's next-write word pointer; MSB is the wrap bit.
- Read_Ptr_O  output  ADDR_WIDTH+1  next word to fetch, with wrap bit; words before it may be overwritten.
- Enable_B_O  output  1  buffer port B enable.
- Address_B_O  output  ADDR_WIDTH  buffer port B address.
- Data_B_I  input  32  buffer port B read data; valid the cycle after Enable_B_O.
- Bits_O  output  32  bit window; Bits_O[31] is the next unconsumed bit.
- Bits_Valid_O  output  1  high when at least 32 bits are buffered.
- Shift_I  input  1  consume request.
- Shift_Amount_I  input  6  bits to consume, 0..32.
- Flush_I  input  1  discard all buffered data and resynchronise to the writer.

Behaviour:
- Reset (async): FSM=IDLE; bit_count=0; 64-bit shift reg=0; rd_ptr=0. Outputs: Enable_B_O=0, Address_B_O=0, Read_Ptr_O=0, Bits_O=0, Bits_Valid_O=0.
- Empty: rd_ptr == Write_Ptr_I (all ADDR_WIDTH+1 bits). Writer guarantees it never laps rd_ptr.
- FSM, three states:
  - IDLE: go to FETCH when not empty, bit_count<=32 and Flush_I=0.
  - FETCH: Enable_B_O=1 and Address_B_O=rd_ptr[ADDR_WIDTH-1:0], both combinational from state. rd_ptr increments at the edge. Next state WAIT.
  - WAIT: Data_B_I is valid. At the edge the word is loaded MSB-first at bit position 64-bit_count (after this cycle's shift) and bit_count+=32. Next state is FETCH if, after the update, bit_count<=32 and not empty; otherwise IDLE.
  - Enable_B_O=0 in IDLE and WAIT.
- Pointer wrap: rd_ptr is ADDR_WIDTH+1 bits and wraps naturally; Address_B_O rolls 511->0.
- Latency: Write_Ptr_I changes from empty at edge 0 -> FETCH in cycle 1 -> WAIT in cycle 2 -> Bits_Valid_O=1 in cycle 3. Peak fill rate is 32 bits per 2 cycles.
- Shift:
  - Accepted only when Shift_I=1 and Bits_Valid_O=1; ignored otherwise.
  - bit_count-=N and the register shifts left N, zero-filling.
  - N>32 is clamped to 32. N=0 is a no-op.
- Simultaneous shift and load in WAIT: shift is applied first, then the word is appended. bit_count_next = bit_count - N + 32. Maximum occupancy is 64.
- Bits_O = shift_reg[63:32]. Bits beyond bit_count read 0.
- Bits_Valid_O = (bit_count>=32), registered with the state.
- Flush_I (synchronous, highest priority):
  - bit_count=0, shift reg=0, FSM=IDLE, rd_ptr=Write_Ptr_I.
  - Any in-flight WAIT word is discarded, and any concurrent shift is ignored.
  - Fetching resumes once the buffer is non-empty.
- Reset mid-fetch: immediate return to reset state; a pending BRAM read is ignored.

Optional Feature:
- Macro: BITSTR_BYTE_ALIGN_EN.
- When defined:
  - Adds input Align_I (1 bit) and a 3-bit consumed-bit counter, bit_pos. bit_pos += N mod 8 on each accepted shift and clears on reset/Flush_I.
  - Align_I with Bits_Valid_O=1 shifts by (8-bit_pos) mod 8, so bit_pos becomes 0.
  - Align_I takes priority over Shift_I in the same cycle.
  - Align_I while already aligned is a no-op.
- When undefined: no Align_I port, no bit_pos logic. Parser performs alignment via Shift_I.

Test Plan:
- Reset, then Write_Ptr_I 0->1 with word 0x000001B3 -> Enable_B_O=1, Address_B_O=0 in cycle 1; Bits_O=0x000001B3 and Bits_Valid_O=1 in cycle 3; Read_Ptr_O=1.
- Words 0x12345678, 0x9ABCDEF0 loaded; shift 8 -> Bits_O=0x3456789A; shift 32 -> Bits_O=0xBCDEF000 with Bits_Valid_O=0 until the next word loads.
- Write_Ptr_I advanced over wrap (rd_ptr 511->512) -> Address_B_O sequence 510, 511, 0, 1; Read_Ptr_O MSB toggles; no stall.
- Shift of 4 in the same cycle as a WAIT load with bit_count=32 -> bit_count=60, data contiguous, no bits lost or duplicated.
- Flush_I during WAIT with Write_Ptr_I=0x00A -> Bits_Valid_O=0 next cycle, Read_Ptr_O=0x00A, stale word not loaded.
- (BITSTR_BYTE_ALIGN_EN) shift 3, then Align_I -> 5 more bits consumed, Bits_O starts on the byte boundary; a second Align_I is a no-op.

Source files
------------

// File: rtl/bitstream_reader_if.sv
// Port-B buffer read bus plus parser bit-window handshake for bitstream_reader.
// Align_I exists only when BITSTR_BYTE_ALIGN_EN is defined.
interface bitstream_reader_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH:0]   Write_Ptr_I;
  logic [ADDR_WIDTH:0]   Read_Ptr_O;
  logic                  Enable_B_O;
  logic [ADDR_WIDTH-1:0] Address_B_O;
  logic [31:0]           Data_B_I;
  logic [31:0]           Bits_O;
  logic                  Bits_Valid_O;
  logic                  Shift_I;
  logic [5:0]            Shift_Amount_I;
  logic                  Flush_I;
`ifdef BITSTR_BYTE_ALIGN_EN
  logic                  Align_I;
`endif

  // Reader side.
  modport master (
    input  Write_Ptr_I, Data_B_I, Shift_I, Shift_Amount_I, Flush_I,
`ifdef BITSTR_BYTE_ALIGN_EN
    input  Align_I,
`endif
    output Read_Ptr_O, Enable_B_O, Address_B_O, Bits_O, Bits_Valid_O
  );

  // Buffer / parser side.
  modport slave (
    output Write_Ptr_I, Data_B_I, Shift_I, Shift_Amount_I, Flush_I,
`ifdef BITSTR_BYTE_ALIGN_EN
    output Align_I,
`endif
    input  Read_Ptr_O, Enable_B_O, Address_B_O, Bits_O, Bits_Valid_O
  );
endinterface

// File: rtl/bitstream_reader.sv
// Bitstream buffer read engine: fetches 32-bit words in order and presents a left-justified
// 32-bit bit window. Optional byte-align command enabled by BITSTR_BYTE_ALIGN_EN.
module bitstream_reader #(
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic               clock,
  input  logic               reset,
  bitstream_reader_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StWait} state_e;

  localparam logic [ADDR_WIDTH:0] PtrOne = 1;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [6:0]          bit_count_q, bit_count_d;
  logic [63:0]         shift_q, shift_d;
  logic                valid_q, valid_d;

  logic                empty;
  logic                shift_req;
  logic [5:0]          shift_amt;
  logic [5:0]          shift_n;
  logic [6:0]          count_s;
  logic [63:0]         reg_s;
  logic [63:0]         word_pos;

  assign empty     = (rd_ptr_q == bus.Write_Ptr_I);
  assign shift_req = bus.Shift_I && valid_q;
  assign shift_amt = (bus.Shift_Amount_I > 6'd32) ? 6'd32 : bus.Shift_Amount_I;

`ifdef BITSTR_BYTE_ALIGN_EN
  logic [2:0] bit_pos_q, bit_pos_d;
  logic [2:0] align_n;
  logic       align_req;

  assign align_n   = 3'd0 - bit_pos_q;
  assign align_req = bus.Align_I && valid_q;

  always_comb begin
    shift_n = '0;
    if (align_req) begin
      shift_n = {3'b000, align_n};
    end else if (shift_req) begin
      shift_n = shift_amt;
    end
  end

  assign bit_pos_d = bus.Flush_I ? 3'd0 : bit_pos_q + shift_n[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_pos_q <= '0;
    end else begin
      bit_pos_q <= bit_pos_d;
    end
  end
`else
  assign shift_n = shift_req ? shift_amt : 6'd0;
`endif

  // Shift is applied before any word load, so a load lands right after the surviving bits.
  assign reg_s    = shift_q << shift_n;
  assign count_s  = bit_count_q - {1'b0, shift_n};
  assign word_pos = {bus.Data_B_I, 32'h0000_0000} >> count_s;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    bit_count_d = count_s;
    shift_d     = reg_s;

    unique case (state_q)
      StIdle: begin
        if (!empty && bit_count_q <= 7'd32) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        rd_ptr_d = rd_ptr_q + PtrOne;
        state_d  = StWait;
      end
      StWait: begin
        // Bits above the occupancy are always zero, so OR-ing appends the word.
        shift_d     = reg_s | word_pos;
        bit_count_d = count_s + 7'd32;
        state_d     = (bit_count_d <= 7'd32 && !empty) ? StFetch : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.Flush_I) begin
      state_d     = StIdle;
      rd_ptr_d    = bus.Write_Ptr_I;
      bit_count_d = '0;
      shift_d     = '0;
    end
  end

  assign valid_d = (bit_count_d >= 7'd32);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.Enable_B_O   = (state_q == StFetch);
  assign bus.Address_B_O  = bus.Enable_B_O ? rd_ptr_q[ADDR_WIDTH-1:0] : '0;
  assign bus.Read_Ptr_O   = rd_ptr_q;
  assign bus.Bits_O       = shift_q[63:32];
  assign bus.Bits_Valid_O = valid_q;

endmodule

// File: tb/tb_bitstream_reader.sv
// Directed self-checking bench for bitstream_reader with a registered-read buffer model.
// Covers the byte-align command when BITSTR_BYTE_ALIGN_EN is defined.
module tb_bitstream_reader;
  localparam int unsigned AW = 9;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bitstream_reader_if #(.ADDR_WIDTH(AW)) bus ();

  bitstream_reader #(.ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] mem [512];
  logic [31:0] rdata;

  always @(posedge clock) begin
    if (bus.Enable_B_O) rdata <= mem[bus.Address_B_O];
  end
  assign bus.Data_B_I = rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic shift(input logic [5:0] amt);
    bus.Shift_I        = 1'b1;
    bus.Shift_Amount_I = amt;
    step();
    bus.Shift_I        = 1'b0;
    bus.Shift_Amount_I = 6'd0;
  endtask

  logic [8:0]  exp_addr [4];
  logic [31:0] exp_word [4];
  logic [8:0]  got_addr [4];
  logic [31:0] got_word [4];
  int          na, nb;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    reset              = 1'b1;
    bus.Write_Ptr_I    = '0;
    bus.Shift_I        = 1'b0;
    bus.Shift_Amount_I = 6'd0;
    bus.Flush_I        = 1'b0;
`ifdef BITSTR_BYTE_ALIGN_EN
    bus.Align_I        = 1'b0;
`endif
    step(2);
    check("rst_enable", bus.Enable_B_O, 0);
    check("rst_addr",   bus.Address_B_O, 0);
    check("rst_rdptr",  bus.Read_Ptr_O, 0);
    check("rst_bits",   bus.Bits_O, 0);
    check("rst_valid",  bus.Bits_Valid_O, 0);
    reset = 1'b0;
    step();

    // First word latency
    mem[0] = 32'h0000_01B3;
    bus.Write_Ptr_I = 10'd1;
    step();
    check("lat_c1_enable", bus.Enable_B_O, 1);
    check("lat_c1_addr",   bus.Address_B_O, 0);
    step();
    check("lat_c2_enable", bus.Enable_B_O, 0);
    check("lat_c2_rdptr",  bus.Read_Ptr_O, 1);
    step();
    check("lat_c3_bits",  bus.Bits_O, 32'h0000_01B3);
    check("lat_c3_valid", bus.Bits_Valid_O, 1);
    shift(6'd32);
    check("drain_valid", bus.Bits_Valid_O, 0);
    check("drain_bits",  bus.Bits_O, 0);

    // Two words, shift 8 then 32
    mem[1] = 32'h1234_5678;
    mem[2] = 32'h9ABC_DEF0;
    bus.Write_Ptr_I = 10'd3;
    step(5);
    check("two_bits",  bus.Bits_O, 32'h1234_5678);
    check("two_valid", bus.Bits_Valid_O, 1);
    shift(6'd8);
    check("sh8_bits", bus.Bits_O, 32'h3456_789A);
    shift(6'd32);
    check("sh32_bits",  bus.Bits_O, 32'hBCDE_F000);
    check("sh32_valid", bus.Bits_Valid_O, 0);
    shift(6'd8);
    check("ignored_shift_bits", bus.Bits_O, 32'hBCDE_F000);

    // Flush, then shift 4 concurrent with a WAIT load at 32 bits
    bus.Flush_I = 1'b1;
    step();
    bus.Flush_I = 1'b0;
    check("flush_bits",  bus.Bits_O, 0);
    check("flush_valid", bus.Bits_Valid_O, 0);
    mem[3] = 32'hA1B2_C3D4;
    mem[4] = 32'h5566_7788;
    bus.Write_Ptr_I = 10'd5;
    step(3);
    check("sl_first_bits", bus.Bits_O, 32'hA1B2_C3D4);
    check("sl_fetch_addr", bus.Address_B_O, 4);
    step();
    shift(6'd4);
    check("sl_bits",  bus.Bits_O, 32'h1B2C_3D45);
    check("sl_valid", bus.Bits_Valid_O, 1);
    shift(6'd28);
    check("sl_tail_bits",  bus.Bits_O, 32'h5566_7788);
    check("sl_tail_valid", bus.Bits_Valid_O, 1);
    shift(6'd40);
    check("clamp_valid", bus.Bits_Valid_O, 0);
    check("clamp_bits",  bus.Bits_O, 0);

    // Pointer wrap 510 -> 513 while streaming 32 bits per valid cycle
    bus.Write_Ptr_I = 10'd510;
    bus.Flush_I = 1'b1;
    step();
    bus.Flush_I = 1'b0;
    mem[510] = 32'hA000_0510;
    mem[511] = 32'hA000_0511;
    mem[0]   = 32'hB000_0000;
    mem[1]   = 32'hB000_0001;
    exp_addr[0] = 9'd510; exp_addr[1] = 9'd511; exp_addr[2] = 9'd0; exp_addr[3] = 9'd1;
    exp_word[0] = 32'hA000_0510; exp_word[1] = 32'hA000_0511;
    exp_word[2] = 32'hB000_0000; exp_word[3] = 32'hB000_0001;
    bus.Write_Ptr_I    = 10'h202;
    bus.Shift_I        = 1'b1;
    bus.Shift_Amount_I = 6'd32;
    na = 0;
    nb = 0;
    for (int cyc = 0; cyc < 40 && (na < 4 || nb < 4); cyc++) begin
      if (bus.Enable_B_O && na < 4) begin
        got_addr[na] = bus.Address_B_O;
        na++;
      end
      if (bus.Bits_Valid_O && nb < 4) begin
        got_word[nb] = bus.Bits_O;
        nb++;
      end
      step();
    end
    bus.Shift_I        = 1'b0;
    bus.Shift_Amount_I = 6'd0;
    check("wrap_addr_count", na, 4);
    check("wrap_word_count", nb, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < na) check($sformatf("wrap_addr%0d", i), got_addr[i], exp_addr[i]);
      if (i < nb) check($sformatf("wrap_word%0d", i), got_word[i], exp_word[i]);
    end
    check("wrap_rdptr", bus.Read_Ptr_O, 10'h202);

    // Flush during WAIT discards the in-flight word
    mem[2] = 32'hDEAD_BEEF;
    bus.Write_Ptr_I = 10'h203;
    step(2);
    bus.Flush_I     = 1'b1;
    bus.Write_Ptr_I = 10'h00A;
    step();
    bus.Flush_I = 1'b0;
    check("fw_valid", bus.Bits_Valid_O, 0);
    check("fw_rdptr", bus.Read_Ptr_O, 10'h00A);
    check("fw_bits",  bus.Bits_O, 0);
    step(3);
    check("fw_stale_bits",   bus.Bits_O, 0);
    check("fw_stale_valid",  bus.Bits_Valid_O, 0);
    check("fw_stale_enable", bus.Enable_B_O, 0);

    // Reset mid-fetch
    mem[10] = 32'h1111_2222;
    bus.Write_Ptr_I = 10'h00B;
    step();
    check("rm_enable", bus.Enable_B_O, 1);
    check("rm_addr",   bus.Address_B_O, 10);
    #2;
    reset = 1'b1;
    bus.Write_Ptr_I = '0;
    #1;
    check("rm_async_enable", bus.Enable_B_O, 0);
    check("rm_async_rdptr",  bus.Read_Ptr_O, 0);
    step();
    reset = 1'b0;
    step(3);
    check("rm_after_valid", bus.Bits_Valid_O, 0);
    check("rm_after_bits",  bus.Bits_O, 0);

`ifdef BITSTR_BYTE_ALIGN_EN
    // Byte align after a 3-bit shift
    mem[0] = 32'h1234_5678;
    mem[1] = 32'h9ABC_DEF0;
    bus.Write_Ptr_I = 10'd2;
    step(5);
    check("al_load_bits", bus.Bits_O, 32'h1234_5678);
    shift(6'd3);
    check("al_sh3_bits", bus.Bits_O, 32'h91A2_B3C4);
    bus.Align_I = 1'b1;
    step();
    check("al_bits", bus.Bits_O, 32'h3456_789A);
    bus.Shift_I        = 1'b1;
    bus.Shift_Amount_I = 6'd8;
    step();
    bus.Align_I        = 1'b0;
    bus.Shift_I        = 1'b0;
    bus.Shift_Amount_I = 6'd0;
    check("al_noop_bits",  bus.Bits_O, 32'h3456_789A);
    check("al_noop_valid", bus.Bits_Valid_O, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
